// File: rtl/reward_pack.sv
// reward_pack: chooses the next outgoing packet for the node (HB ripple,
// INV ripple, MR, Data/SOS forward, CH INV, CHT or own Data), packs it from
// own-node, kCH and neighbour fields and offers it to the transmitter over a
// valid/ready handshake. Also owns the HB lock and the cluster-formation timer.
// Optional build macro: REWARD_HOLD_ABORT_EN -- drop a packet the transmitter
// leaves waiting for HOLD_LIMIT+1 cycles and queue it again for a retry.
module reward_pack #(
    parameter int WORD_WIDTH  = 16,
    parameter int MAX_CH_HOPS = 4,
    parameter int MR_TIMEOUT  = 15,
    parameter int CHT_TIMEOUT = 31,
    parameter int TIMER_WIDTH = 16,
    parameter int HOLD_LIMIT  = 63
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic                  role,
    input  logic                  cf_start,
    input  logic                  ch_inv_req,
    input  logic                  iAmSender,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    input  logic [WORD_WIDTH-1:0] mNodeCHHops,
    input  logic [WORD_WIDTH-1:0] nextHopID,
    input  logic                  pkt_ready,
    output logic                  pkt_valid,
    output logic [WORD_WIDTH-1:0] rSourceID,
    output logic [WORD_WIDTH-1:0] rEnergyLeft,
    output logic [WORD_WIDTH-1:0] rQValue,
    output logic [WORD_WIDTH-1:0] rSourceHops,
    output logic [WORD_WIDTH-1:0] rDestinationID,
    output logic [WORD_WIDTH-1:0] rChosenCH,
    output logic [WORD_WIDTH-1:0] rHopsFromCH,
    output logic [2:0]            rPacketType,
    output logic                  reward_done,
    output logic                  busy
);

    localparam logic [2:0] PT_HB   = 3'b000;
    localparam logic [2:0] PT_INV  = 3'b010;
    localparam logic [2:0] PT_MR   = 3'b011;
    localparam logic [2:0] PT_CHT  = 3'b100;
    localparam logic [2:0] PT_DATA = 3'b101;
    localparam logic [2:0] PT_SOS  = 3'b110;
    localparam logic [2:0] PT_NONE = 3'b111;

    localparam logic [WORD_WIDTH-1:0]  BCAST    = '1;
    localparam logic [WORD_WIDTH-1:0]  MAX_HOPS = WORD_WIDTH'(MAX_CH_HOPS);
    localparam logic [TIMER_WIDTH-1:0] MR_LOAD  = TIMER_WIDTH'(MR_TIMEOUT);
    localparam logic [TIMER_WIDTH-1:0] CHT_LOAD = TIMER_WIDTH'(CHT_TIMEOUT);
    localparam logic [TIMER_WIDTH-1:0] TMR_ONE  = TIMER_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_PACK, S_HOLD, S_DONE
    } state_t;

    // Request sources; the encoding doubles as the pending-flag bit index and
    // lower index means higher priority.
    typedef enum logic [2:0] {
        SRC_HB    = 3'd0,
        SRC_INV   = 3'd1,
        SRC_CHT   = 3'd2,
        SRC_MR    = 3'd3,
        SRC_CHINV = 3'd4,
        SRC_FWD   = 3'd5,
        SRC_OWN   = 3'd6
    } src_t;

    state_t                  state, state_nxt;
    src_t                    sel_q, pick;
    logic [6:0]              pend, set_vec, clr_vec;
    logic [TIMER_WIDTH-1:0]  tmr;
    logic                    armed, tmr_expire;
    logic                    hb_lock;
    logic                    cap_hb, cap_inv, cap_fwd, cap_chinv;
    logic                    hold_abort;
    logic [WORD_WIDTH-1:0]   inv_hops;
    logic [2:0]              fwd_type;
    logic                    unused_inputs;

    // The received source ID is not carried into any packet this stage builds.
    assign unused_inputs = ^mNodeID;

    // Hop count carried by a rippled INV; the caller guarantees no overflow.
    function automatic logic [WORD_WIDTH-1:0] hop_inc(input logic [WORD_WIDTH-1:0] h);
        return h + WORD_WIDTH'(1);
    endfunction

    // Fixed-priority pick of the highest pending request.
    function automatic src_t pick_src(input logic [6:0] p);
        if (p[SRC_HB])         return SRC_HB;
        else if (p[SRC_INV])   return SRC_INV;
        else if (p[SRC_CHT])   return SRC_CHT;
        else if (p[SRC_MR])    return SRC_MR;
        else if (p[SRC_CHINV]) return SRC_CHINV;
        else if (p[SRC_FWD])   return SRC_FWD;
        else                   return SRC_OWN;
    endfunction

    assign cap_hb     = en && (fPacketType == PT_HB) && !hb_lock;
    assign cap_inv    = en && (fPacketType == PT_INV) && (mNodeCHHops < MAX_HOPS);
    assign cap_fwd    = en && ((fPacketType == PT_DATA) || (fPacketType == PT_SOS)) && iAmDestination;
    assign cap_chinv  = ch_inv_req && role;
    assign tmr_expire = armed && !cf_start && (tmr == TMR_ONE);
    assign pick       = pick_src(pend);

`ifdef REWARD_HOLD_ABORT_EN
    logic [TIMER_WIDTH-1:0] hold_cnt;

    assign hold_abort = (state == S_HOLD) && !pkt_ready &&
                        (hold_cnt == TIMER_WIDTH'(HOLD_LIMIT));

    // Counts cycles spent waiting in S_HOLD; restarts for every packet.
    always_ff @(posedge clk) begin
        if (!nrst)
            hold_cnt <= '0;
        else if (state == S_HOLD)
            hold_cnt <= hold_cnt + TIMER_WIDTH'(1);
        else
            hold_cnt <= '0;
    end
`else
    logic unused_hold_limit;

    assign hold_abort        = 1'b0;
    assign unused_hold_limit = (HOLD_LIMIT != 0);
`endif

    // Build the per-cycle set and clear masks for the pending flags.
    always_comb begin
        set_vec            = '0;
        set_vec[SRC_HB]    = cap_hb;
        set_vec[SRC_INV]   = cap_inv;
        set_vec[SRC_CHT]   = tmr_expire && role;
        set_vec[SRC_MR]    = tmr_expire && !role;
        set_vec[SRC_CHINV] = cap_chinv;
        set_vec[SRC_FWD]   = cap_fwd;
        set_vec[SRC_OWN]   = iAmSender;
        if (hold_abort)
            set_vec = set_vec | (7'(1) << sel_q);
        clr_vec = '0;
        if (state == S_SELECT)
            clr_vec = 7'(1) << pick;
    end

    // Sticky pending flags; a new request in the select cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!nrst)
            pend <= '0;
        else
            pend <= (pend & ~clr_vec) | set_vec;
    end

    // Per-request data that must survive until the packet is packed.
    always_ff @(posedge clk) begin
        if (cap_inv)
            inv_hops <= mNodeCHHops;
        if (cap_fwd)
            fwd_type <= fPacketType;
    end

    // Cluster-formation timeout: load on cf_start, count down, flag on 1 -> 0.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            tmr   <= '0;
            armed <= 1'b0;
        end else if (cf_start) begin
            tmr   <= role ? CHT_LOAD : MR_LOAD;
            armed <= 1'b1;
        end else if (armed) begin
            if (tmr != '0)
                tmr <= tmr - TMR_ONE;
            if (tmr <= TMR_ONE)
                armed <= 1'b0;
        end
    end

    // HB lock: one HB ripple per Data epoch.
    always_ff @(posedge clk) begin
        if (!nrst)
            hb_lock <= 1'b0;
        else if ((state == S_HOLD) && pkt_ready && (sel_q == SRC_HB))
            hb_lock <= 1'b1;
        else if (en && (fPacketType == PT_DATA))
            hb_lock <= 1'b0;
    end

    // FSM state register and the request chosen in S_SELECT.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= S_IDLE;
            sel_q <= SRC_HB;
        end else begin
            state <= state_nxt;
            if (state == S_SELECT)
                sel_q <= pick;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        pkt_valid   = 1'b0;
        reward_done = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE:   if (|pend) state_nxt = S_SELECT;
            S_SELECT: state_nxt = S_PACK;
            S_PACK:   state_nxt = S_HOLD;
            S_HOLD: begin
                pkt_valid = 1'b1;
                if (pkt_ready || hold_abort)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                reward_done = 1'b1;
                state_nxt   = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Packet fields are registered in S_PACK and held through S_HOLD.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rSourceID      <= '0;
            rEnergyLeft    <= '0;
            rQValue        <= '0;
            rSourceHops    <= '0;
            rDestinationID <= '0;
            rChosenCH      <= '0;
            rHopsFromCH    <= '0;
            rPacketType    <= PT_NONE;
        end else if (state == S_PACK) begin
            rSourceID      <= myNodeID;
            rEnergyLeft    <= myEnergy;
            rQValue        <= myQValue;
            rSourceHops    <= hopsFromSink;
            rDestinationID <= BCAST;
            rChosenCH      <= '0;
            rHopsFromCH    <= '0;
            case (sel_q)
                SRC_HB: rPacketType <= PT_HB;
                SRC_INV: begin
                    rPacketType <= PT_INV;
                    rChosenCH   <= chosenCH;
                    rHopsFromCH <= hop_inc(inv_hops);
                end
                SRC_CHT: begin
                    rPacketType <= PT_CHT;
                    rChosenCH   <= myNodeID;
                end
                SRC_MR: begin
                    rPacketType    <= PT_MR;
                    rDestinationID <= chosenCH;
                    rHopsFromCH    <= hopsFromCH;
                end
                SRC_CHINV: begin
                    rPacketType <= PT_INV;
                    rChosenCH   <= myNodeID;
                end
                SRC_FWD: begin
                    rPacketType    <= fwd_type;
                    rDestinationID <= nextHopID;
                end
                SRC_OWN: begin
                    rPacketType    <= PT_DATA;
                    rDestinationID <= nextHopID;
                end
                default: rPacketType <= PT_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_reward_pack.sv
// Bench for reward_pack: table of single-request vectors plus hand-written
// multi-cycle sequences; packets are checked against a queue of expectations.
`timescale 1ns/1ps
module tb_reward_pack;

    localparam int W = 16;
    localparam logic [W-1:0] MY_ID   = 16'h0011;
    localparam logic [W-1:0] MY_HOPS = 16'h0003;
    localparam logic [W-1:0] MY_Q    = 16'h0A0A;
    localparam logic [W-1:0] MY_E    = 16'h0BEE;
    localparam logic [W-1:0] K_CH    = 16'h0042;
    localparam logic [W-1:0] K_HOPS  = 16'h0002;
    localparam logic [W-1:0] NEXT    = 16'h0077;
    localparam logic [W-1:0] BC      = 16'hFFFF;
    localparam logic [W-1:0] Z       = 16'h0000;

    logic         clk = 1'b0;
    logic         nrst = 1'b0, en = 1'b0, iAmDestination = 1'b0, role = 1'b0;
    logic         cf_start = 1'b0, ch_inv_req = 1'b0, iAmSender = 1'b0, pkt_ready = 1'b1;
    logic [2:0]   fPacketType = 3'b000;
    logic [W-1:0] mNodeCHHops = '0;
    logic         pkt_valid, reward_done, busy;
    logic [W-1:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH;
    logic [2:0]   rPacketType;

    int n_checks = 0;
    int n_pass   = 0;
    logic [114:0] sb[$];

    always #5 clk = ~clk;

    reward_pack #(.HOLD_LIMIT(7)) dut (
        .clk(clk), .nrst(nrst), .en(en), .fPacketType(fPacketType),
        .iAmDestination(iAmDestination), .role(role), .cf_start(cf_start),
        .ch_inv_req(ch_inv_req), .iAmSender(iAmSender),
        .myNodeID(MY_ID), .hopsFromSink(MY_HOPS), .myQValue(MY_Q), .myEnergy(MY_E),
        .chosenCH(K_CH), .hopsFromCH(K_HOPS), .mNodeID(16'h0055),
        .mNodeCHHops(mNodeCHHops), .nextHopID(NEXT), .pkt_ready(pkt_ready),
        .pkt_valid(pkt_valid), .rSourceID(rSourceID), .rEnergyLeft(rEnergyLeft),
        .rQValue(rQValue), .rSourceHops(rSourceHops), .rDestinationID(rDestinationID),
        .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH), .rPacketType(rPacketType),
        .reward_done(reward_done), .busy(busy)
    );

    typedef struct {
        logic       en;
        logic [2:0] pt;
        logic       dst;
        logic [W-1:0] mh;
        logic       snd;
        logic       chinv;
        logic       role;
        logic       exp_pkt;
        logic [2:0] e_pt;
        logic [W-1:0] e_dest;
        logic [W-1:0] e_ch;
        logic [W-1:0] e_hfc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [114:0] mkpkt(input logic [2:0] pt, input logic [W-1:0] dest,
                                           input logic [W-1:0] ch, input logic [W-1:0] hfc);
        return {pt, MY_ID, MY_E, MY_Q, MY_HOPS, dest, ch, hfc};
    endfunction

    function automatic logic [114:0] act_pkt();
        return {rPacketType, rSourceID, rEnergyLeft, rQValue, rSourceHops,
                rDestinationID, rChosenCH, rHopsFromCH};
    endfunction

    task automatic drive_idle();
        en = 1'b0; fPacketType = 3'b000; iAmDestination = 1'b0; mNodeCHHops = '0;
        iAmSender = 1'b0; ch_inv_req = 1'b0; cf_start = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output int lat);
        lat = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (pkt_valid) begin lat = c; break; end
        end
    endtask

    task automatic wait_done(input int maxc, output int lat);
        lat = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (reward_done) begin lat = c; break; end
        end
    endtask

    // One-cycle en strobe of a given type (used to clear the HB lock).
    task automatic pulse_en(input logic [2:0] pt, input logic d);
        en = 1'b1; fPacketType = pt; iAmDestination = d;
        @(negedge clk);
        drive_idle();
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard side: a handshake seen here completes on the next posedge.
    always @(negedge clk) begin
        #2;
        if (nrst && pkt_valid && pkt_ready) begin
            chk("pkt_expected", {127'b0, sb.size() != 0}, 128'd1);
            if (sb.size() != 0) chk("pkt_fields", act_pkt(), sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, cnt, bad;
        logic [114:0] snap;
        vec_t v;

        vecs[0]  = '{1'b1, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, BC,   Z,     Z};
        vecs[1]  = '{1'b1, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, Z,    Z,     Z};
        vecs[2]  = '{1'b1, 3'b101, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, Z,    Z,     Z};
        vecs[3]  = '{1'b1, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, BC,   Z,     Z};
        vecs[4]  = '{1'b1, 3'b010, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, BC,   K_CH,  16'd3};
        vecs[5]  = '{1'b1, 3'b010, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, Z,    Z,     Z};
        vecs[6]  = '{1'b1, 3'b010, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, BC,   K_CH,  16'd4};
        vecs[7]  = '{1'b1, 3'b101, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, NEXT, Z,     Z};
        vecs[8]  = '{1'b1, 3'b110, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, NEXT, Z,     Z};
        vecs[9]  = '{1'b1, 3'b110, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, Z,    Z,     Z};
        vecs[10] = '{1'b1, 3'b001, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, Z,    Z,     Z};
        vecs[11] = '{1'b1, 3'b011, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, Z,    Z,     Z};
        vecs[12] = '{1'b0, 3'b000, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b101, NEXT, Z,     Z};
        vecs[13] = '{1'b0, 3'b000, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, BC,   MY_ID, Z};
        vecs[14] = '{1'b0, 3'b000, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, Z,    Z,     Z};
        vecs[15] = '{1'b1, 3'b100, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, Z,    Z,     Z};

        // Reset state
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {127'b0, pkt_valid}, 128'd0);
        chk("rst_done", {127'b0, reward_done}, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_type", {125'b0, rPacketType}, 128'd7);
        chk("rst_dest", {112'b0, rDestinationID}, 128'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Single-request vectors
        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            if (v.exp_pkt) sb.push_back(mkpkt(v.e_pt, v.e_dest, v.e_ch, v.e_hfc));
            role = v.role;
            en = v.en; fPacketType = v.pt; iAmDestination = v.dst; mNodeCHHops = v.mh;
            iAmSender = v.snd; ch_inv_req = v.chinv;
            @(negedge clk);
            drive_idle();
            if (v.exp_pkt) begin
                wait_valid(10, lat);
                chk($sformatf("vec%0d_latency", i), lat, 128'd3);
                wait_done(5, lat);
                chk($sformatf("vec%0d_done", i), lat, 128'd1);
                @(negedge clk);
            end else begin
                cnt = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (busy || pkt_valid) cnt++;
                end
                chk($sformatf("vec%0d_no_pkt", i), cnt, 128'd0);
            end
        end
        role = 1'b0;

        // MR timeout
        sb.push_back(mkpkt(3'b011, K_CH, Z, K_HOPS));
        cf_start = 1'b1;
        @(negedge clk);
        drive_idle();
        wait_valid(40, lat);
        chk("mr_latency", lat, 128'd18);
        wait_done(5, lat);
        chk("mr_done", lat, 128'd1);
        @(negedge clk);

        // CHT timeout
        role = 1'b1;
        sb.push_back(mkpkt(3'b100, BC, MY_ID, Z));
        cf_start = 1'b1;
        @(negedge clk);
        drive_idle();
        wait_valid(60, lat);
        chk("cht_latency", lat, 128'd34);
        wait_done(5, lat);
        chk("cht_done", lat, 128'd1);
        role = 1'b0;
        @(negedge clk);

        // HB and own data together: HB first, then Data
        pulse_en(3'b101, 1'b0);
        sb.push_back(mkpkt(3'b000, BC, Z, Z));
        sb.push_back(mkpkt(3'b101, NEXT, Z, Z));
        en = 1'b1; fPacketType = 3'b000; iAmSender = 1'b1;
        @(negedge clk);
        drive_idle();
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (reward_done) cnt++;
        end
        chk("dual_done_pulses", cnt, 128'd2);
        chk("dual_sb_empty", sb.size(), 128'd0);

        // Transmitter stalls with pkt_ready low
        pulse_en(3'b101, 1'b0);
        sb.push_back(mkpkt(3'b000, BC, Z, Z));
        pkt_ready = 1'b0;
        en = 1'b1; fPacketType = 3'b000;
        @(negedge clk);
        drive_idle();
        wait_valid(10, lat);
        chk("stall_latency", lat, 128'd3);
        snap = act_pkt();
        bad = 0;
`ifdef REWARD_HOLD_ABORT_EN
        repeat (7) begin
            @(negedge clk);
            if (!pkt_valid || act_pkt() !== snap) bad++;
        end
        chk("abort_hold_stable", bad, 128'd0);
        @(negedge clk);
        chk("abort_valid_drop", {127'b0, pkt_valid}, 128'd0);
        chk("abort_done_pulse", {127'b0, reward_done}, 128'd1);
        wait_valid(10, lat);
        chk("abort_retry_latency", lat, 128'd4);
`else
        repeat (19) begin
            @(negedge clk);
            if (!pkt_valid || act_pkt() !== snap) bad++;
        end
        chk("stall_stable", bad, 128'd0);
`endif
        pkt_ready = 1'b1;
        wait_done(5, lat);
        chk("stall_done", lat, 128'd1);
        @(negedge clk);

        // Reset while a packet waits in S_HOLD with other work pending
        pulse_en(3'b101, 1'b0);
        pkt_ready = 1'b0;
        en = 1'b1; fPacketType = 3'b000; iAmSender = 1'b1; cf_start = 1'b1;
        @(negedge clk);
        drive_idle();
        wait_valid(10, lat);
        chk("rsthold_latency", lat, 128'd3);
        nrst = 1'b0;
        @(negedge clk);
        chk("rsthold_valid", {127'b0, pkt_valid}, 128'd0);
        chk("rsthold_type", {125'b0, rPacketType}, 128'd7);
        chk("rsthold_busy", {127'b0, busy}, 128'd0);
        nrst = 1'b1;
        pkt_ready = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || pkt_valid) cnt++;
        end
        chk("rsthold_quiet", cnt, 128'd0);
        chk("final_sb_empty", sb.size(), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
